// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES inverse SubBytes over a 128-bit state.
// LANES inverse S-boxes are shared across the 16 bytes, one group of LANES bytes per cycle.

module inverse_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_aff;
  logic [7:0] w_inv;

  // Inverse affine transform, applied before the field inversion
  assign w_aff = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                 {i_byte[1:0], i_byte[7:2]} ^ 8'h05;

  // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0
  always_comb begin
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = w_aff;
    acc = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    w_inv = acc;
  end

  assign o_byte = w_inv;
endmodule

module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int BEATS = 16 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [127:0]           r_src;
  logic [127:0]           r_res;
  logic [LANES-1:0][7:0]  w_lane_in;
  logic [LANES-1:0][7:0]  w_lane_out;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_in[l] = r_src[8*(int'(r_cnt)*LANES + l) +: 8];
    inverse_sbox u_sbox (
      .i_byte (w_lane_in[l]),
      .o_byte (w_lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_src   <= in_data;
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          for (int l = 0; l < LANES; l++)
            r_res[8*(int'(r_cnt)*LANES + l) +: 8] <= w_lane_out[l];
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_BUSY);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_res;
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: directed handshake/reset cases on LANES=4 and
// random back-to-back throughput runs on LANES=16, 4 and 1 against a table model.

module tb_inv_sub_bytes_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: forward S-box generated from the field generator 3, then inverted
  logic [7:0] sbox    [256];
  logic [7:0] inv_tbl [256];
  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tbl[sbox[i]] = 8'(i);
  end

  function automatic logic [127:0] ref_isb(input logic [127:0] d);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = inv_tbl[d[8*j +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Directed DUT, LANES=4
  logic         d_rn, d_iv, d_ir, d_ov, d_or, d_bz;
  logic [127:0] d_id, d_od;

  inv_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk       (clk),
    .reset_n   (d_rn),
    .in_valid  (d_iv),
    .in_ready  (d_ir),
    .in_data   (d_id),
    .out_valid (d_ov),
    .out_ready (d_or),
    .out_data  (d_od),
    .busy      (d_bz)
  );

  task automatic run_block(input string tag, input logic [127:0] d, input logic [127:0] e);
    int t;
    @(negedge clk);
    chk({tag, "_rdy"}, d_ir, 1'b1);
    d_id = d; d_iv = 1'b1; d_or = 1'b1;
    @(posedge clk); #1 d_iv = 1'b0;
    t = 0;
    while (!d_ov && t < 40) begin @(posedge clk); #1; t++; end
    chk({tag, "_lat"}, t, 4);
    chk({tag, "_data"}, d_od, e);
    @(posedge clk); #1;
    chk({tag, "_pop"}, {d_ir, d_ov, d_bz}, 3'b100);
  endtask

  // Throughput DUTs: back-to-back blocks, out_ready tied high
  for (genvar g = 0; g < 3; g++) begin : g_thr
    localparam int L = (g == 0) ? 16 : (g == 1) ? 4 : 1;
    localparam int N = 16 / L;
    logic         rn, iv, ir, ov, bz, done_g;
    logic         orr;
    logic [127:0] id, od;
    int           cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    inv_sub_bytes_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .reset_n   (rn),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .out_valid (ov),
      .out_ready (orr),
      .out_data  (od),
      .busy      (bz)
    );

    initial begin
      int t, acc_cyc, prev_acc;
      logic [127:0] d, e;
      done_g = 1'b0; rn = 1'b0; iv = 1'b0; orr = 1'b1; id = '0;
      repeat (2) @(negedge clk);
      rn = 1'b1;
      prev_acc = -1;
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        d = rand128();
        e = ref_isb(d);
        id = d; iv = 1'b1;
        t = 0;
        while (!ir && t < 40) begin @(negedge clk); t++; end
        if (!ir) begin chk($sformatf("thr%0d_accept_timeout", L), ir, 1'b1); break; end
        @(posedge clk);
        acc_cyc = cyc;
        if (prev_acc >= 0) chk($sformatf("thr%0d_period", L), acc_cyc - prev_acc, N + 2);
        prev_acc = acc_cyc;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!ov && t < 40);
        chk($sformatf("thr%0d_lat", L), t, N);
        chk($sformatf("thr%0d_flags", L), {ov, bz}, 2'b10);
        chk($sformatf("thr%0d_data", L), od, e);
      end
      iv = 1'b0;
      done_g = 1'b1;
    end
  end

  initial begin
    int spur, guard;
    logic [127:0] d, last;
    d_rn = 1'b0; d_iv = 1'b0; d_or = 1'b0; d_id = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {d_ir, d_ov, d_bz}, 3'b100);
    chk("rst_data", d_od, 128'h0);
    d_rn = 1'b1;

    // 63 bytes map to 00, busy for four cycles, then held with out_ready low
    @(negedge clk);
    d_id = {16{8'h63}}; d_iv = 1'b1; d_or = 1'b0;
    @(posedge clk); #1 d_iv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("s63_busy", {d_bz, d_ov}, 2'b10);
      @(posedge clk); #1;
    end
    chk("s63_valid", {d_ov, d_bz}, 2'b10);
    chk("s63_data", d_od, 128'h0);

    for (int i = 0; i < 10; i++) begin
      d_iv = i[0];
      d_id = rand128();
      @(posedge clk); #1;
      chk("hold_data", d_od, 128'h0);
      chk("hold_flags", {d_ir, d_ov, d_bz}, 3'b010);
    end
    d_iv = 1'b0; d_or = 1'b1;
    @(posedge clk); #1 d_or = 1'b0;
    chk("hold_pop", {d_ir, d_ov, d_bz}, 3'b100);
    @(posedge clk); #1;
    chk("hold_no_accept", {d_ir, d_bz}, 2'b10);

    run_block("zero", 128'h0, {16{8'h52}});
    run_block("mix", {{14{8'h63}}, 8'h16, 8'h7C}, {{14{8'h00}}, 8'hFF, 8'h01});
    for (int k = 0; k < 20; k++) begin
      d = rand128();
      run_block("rnd", d, ref_isb(d));
    end

    // Result survives idle cycles with random in_data but no in_valid
    last = d_od;
    d_or = 1'b0;
    repeat (3) begin d_id = rand128(); @(posedge clk); #1; end
    chk("idle_keep", d_od, last);

    // Reset during the second BUSY cycle aborts the block
    @(negedge clk);
    d_id = rand128(); d_iv = 1'b1;
    @(posedge clk); #1 d_iv = 1'b0;
    @(posedge clk); #1 d_rn = 1'b0;
    @(posedge clk); #1 d_rn = 1'b1;
    chk("abort_flags", {d_ir, d_ov, d_bz}, 3'b100);
    chk("abort_data", d_od, 128'h0);
    spur = 0;
    repeat (20) begin @(posedge clk); #1; if (d_ov || d_bz) spur++; end
    chk("abort_spurious", spur, 0);

    // Reset wins over a simultaneous offer
    d_rn = 1'b0; d_iv = 1'b1; d_id = rand128();
    @(posedge clk); #1 d_rn = 1'b1; d_iv = 1'b0;
    chk("rst_prio", {d_ir, d_bz}, 2'b10);

    d = rand128();
    run_block("post_rst", d, ref_isb(d));

    guard = 0;
    while (!(g_thr[0].done_g && g_thr[1].done_g && g_thr[2].done_g) && guard < 60000) begin
      @(negedge clk); guard++;
    end
    chk("thr_complete", {g_thr[0].done_g, g_thr[1].done_g, g_thr[2].done_g}, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
